mux_4_by_1_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the 4x1 multiplexer datapath between four requesters. It registers a one-hot grant and the matching 2-bit `sel_mux`, and steers the selected requester's data word to a single valid/ready output channel. A grant is held for a bounded burst of transfers, then passed on fairly. It sits directly in front of the mux select input and owns `sel_mux` exclusively.

---
 rtl/mux_4_by_1_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux_4_by_1_rr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_4_by_1_rr_arbiter.sv
// Round-robin arbiter and sequencer in front of a shared 4x1 data mux.
// Holds a registered one-hot grant and matching select for a bounded burst
// of transfers, then passes ownership on fairly. Owner index and sel_mux are
// the same register: sel_mux always names the current (or last) owner.
module mux_4_by_1_rr_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [DATA_W-1:0] in_data_3,
    input  logic [DATA_W-1:0] in_data_4,
    input  logic              out_ready,
    output logic [3:0]        gnt,
    output logic [1:0]        sel_mux,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam logic StIdle  = 1'b0;
    localparam logic StGrant = 1'b1;

    // Count value at which the next transfer ends the burst.
    localparam logic [3:0] LastCnt = 4'(MAX_BURST - 1);

    logic       state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;

    logic owner_req;
    logic xfer;
    logic release_gnt;

    // First set bit of r scanning p, p+1, ... modulo 4. Scanning the highest
    // offset first lets the lowest offset overwrite it and win.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        win = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    // Transfer and release conditions for the active owner.
    always_comb begin
        owner_req   = req[sel_q];
        xfer        = (state_q == StGrant) && owner_req && out_ready;
        release_gnt = (state_q == StGrant) &&
                      (!owner_req || (xfer && (cnt_q == LastCnt)));
    end

    // Next-state: arbitration from idle, burst counting, release and handover.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    state_d = StGrant;
                    sel_d   = rr_pick(req, ptr_q);
                    gnt_d   = 4'b0001 << sel_d;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                if (release_gnt) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = 4'd0;
                    if (req != 4'b0000) begin
                        // Scanning from owner+1 visits the releasing owner
                        // last, so it is re-granted only when nobody else asks.
                        sel_d = rr_pick(req, sel_q + 2'd1);
                        gnt_d = 4'b0001 << sel_d;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Output channel: valid follows the owner's request, data follows sel_mux.
    always_comb begin
        gnt       = gnt_q;
        sel_mux   = sel_q;
        busy      = (state_q == StGrant);
        out_valid = (state_q == StGrant) && req[sel_q];
        case (sel_q)
            2'd0:    out_data = in_data_1;
            2'd1:    out_data = in_data_2;
            2'd2:    out_data = in_data_3;
            default: out_data = in_data_4;
        endcase
    end

endmodule

// File: tb/tb_mux_4_by_1_rr_arbiter.sv
// Directed bench for mux_4_by_1_rr_arbiter: one table-driven sequence on a
// MAX_BURST=4 instance, plus hand sequences for round-robin order at
// MAX_BURST=2 and 1, and an asynchronous reset in the middle of a burst.
module tb_mux_4_by_1_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] in_data_1, in_data_2, in_data_3, in_data_4;
    logic       out_ready;

    logic [3:0] gnt4, gnt2, gnt1;
    logic [1:0] sel4, sel2, sel1;
    logic       valid4, valid2, valid1;
    logic [7:0] data4, data2, data1;
    logic       busy4, busy2, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    mux_4_by_1_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in_data_1(in_data_1), .in_data_2(in_data_2),
        .in_data_3(in_data_3), .in_data_4(in_data_4),
        .out_ready(out_ready), .gnt(gnt4), .sel_mux(sel4),
        .out_valid(valid4), .out_data(data4), .busy(busy4)
    );

    mux_4_by_1_rr_arbiter #(.DATA_W(8), .MAX_BURST(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in_data_1(in_data_1), .in_data_2(in_data_2),
        .in_data_3(in_data_3), .in_data_4(in_data_4),
        .out_ready(out_ready), .gnt(gnt2), .sel_mux(sel2),
        .out_valid(valid2), .out_data(data2), .busy(busy2)
    );

    mux_4_by_1_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in_data_1(in_data_1), .in_data_2(in_data_2),
        .in_data_3(in_data_3), .in_data_4(in_data_4),
        .out_ready(out_ready), .gnt(gnt1), .sel_mux(sel1),
        .out_valid(valid1), .out_data(data1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       busy;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] r, input logic rdy, input logic [3:0] g,
                                input logic [1:0] s, input logic v, input logic b,
                                input logic [7:0] d);
        vec_t t;
        t.req = r; t.rdy = rdy; t.gnt = g; t.sel = s; t.valid = v; t.busy = b; t.data = d;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;
        in_data_1 = 8'hA5;
        in_data_2 = 8'h5A;
        in_data_3 = 8'hC3;
        in_data_4 = 8'h3C;

        // Hand-computed timeline for MAX_BURST=4; each row is driven before an
        // edge and checked 1 ns after it.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 8'h00));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(4'b0001, 1, 4'b0001, 0, 1, 1, 8'hA5));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0011, 1, 4'b0001, 0, 1, 1, 8'hA5));
        vecs.push_back(mk(4'b0011, 1, 4'b0010, 1, 1, 1, 8'h5A));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0010, 0, 4'b0010, 1, 1, 1, 8'h5A));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0110, 1, 4'b0010, 1, 1, 1, 8'h5A));
        vecs.push_back(mk(4'b0110, 1, 4'b0100, 2, 1, 1, 8'hC3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b0100, 0, 4'b0100, 2, 1, 1, 8'hC3));
        vecs.push_back(mk(4'b0100, 1, 4'b0100, 2, 1, 1, 8'hC3));
        vecs.push_back(mk(4'b1000, 1, 4'b1000, 3, 1, 1, 8'h3C));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(4'b0000, 1, 4'b0000, 3, 0, 0, 8'h00));
        vecs.push_back(mk(4'b1001, 1, 4'b0001, 0, 1, 1, 8'hA5));
        vecs.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 8'h00));

        // Reset state while reset is held.
        #2;
        check("rst_gnt", 0, gnt4, 4'b0000);
        check("rst_sel", 0, sel4, 2'd0);
        check("rst_valid", 0, valid4, 1'b0);
        check("rst_busy", 0, busy4, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check("tbl_gnt", i, gnt4, vecs[i].gnt);
            check("tbl_sel", i, sel4, vecs[i].sel);
            check("tbl_valid", i, valid4, vecs[i].valid);
            check("tbl_busy", i, busy4, vecs[i].busy);
            if (vecs[i].valid && vecs[i].rdy) check("tbl_data", i, data4, vecs[i].data);
        end

        // Full load round-robin: MAX_BURST=2 gives 0,0,1,1,2,2,3,3,0 and
        // MAX_BURST=1 gives 0,1,2,3,0,... with one transfer per cycle.
        do_reset();
        in_data_1 = 8'h11;
        in_data_2 = 8'h22;
        in_data_3 = 8'h33;
        in_data_4 = 8'h44;
        req       = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            logic [1:0] e2;
            logic [1:0] e1;
            logic [7:0] d2;
            e2 = 2'((i / 2) % 4);
            e1 = 2'(i % 4);
            d2 = 8'h11 * (8'(e2) + 8'd1);
            check("rr2_sel", i, sel2, e2);
            check("rr2_gnt", i, gnt2, 4'b0001 << e2);
            check("rr2_valid", i, valid2, 1'b1);
            check("rr2_data", i, data2, d2);
            check("rr1_sel", i, sel1, e1);
            check("rr1_gnt", i, gnt1, 4'b0001 << e1);
            check("rr1_data", i, data1, 8'h11 * (8'(e1) + 8'd1));
            check("rr1_busy", i, busy1, 1'b1);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-burst after the pointer has moved to 3.
        do_reset();
        req = 4'b0100;
        @(posedge clk);
        #1;
        check("ar_gnt_own2", 0, gnt4, 4'b0100);
        @(negedge clk);
        req = 4'b1000;
        @(posedge clk);
        #1;
        check("ar_gnt_own3", 0, gnt4, 4'b1000);
        check("ar_sel_own3", 0, sel4, 2'd3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_gnt", 0, gnt4, 4'b0000);
        check("ar_sel", 0, sel4, 2'd0);
        check("ar_valid", 0, valid4, 1'b0);
        check("ar_busy", 0, busy4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        @(posedge clk);
        #1;
        check("ar_regnt", 0, gnt4, 4'b0001);
        check("ar_resel", 0, sel4, 2'd0);
        check("ar_redata", 0, data4, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
